// File: rtl/ta_seq_pkg.sv
// Shared definitions for the 68040 transfer-acknowledge sequencer.
// Build option TA_SEQ_TIMEOUT_EN adds the bus-timeout states.
package ta_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BEAT,
    ST_RECOVER
`ifdef TA_SEQ_TIMEOUT_EN
    , ST_TIMEOUT,
    ST_TEA
`endif
  } state_e;

  localparam logic [1:0] SIZ_LINE   = 2'b11;
  localparam int         LINE_BEATS = 4;

  localparam int WAIT_VEC_MAX   = 256;
  localparam int WAIT_FIELD_MAX = 16;

  // Callers zero-extend their packed wait vector to WAIT_VEC_MAX bits.
  function automatic logic [WAIT_FIELD_MAX-1:0] wait_field(
    input logic [WAIT_VEC_MAX-1:0] vec,
    input int                      idx,
    input int                      w
  );
    logic [WAIT_VEC_MAX-1:0] sh;
    sh = (vec >> (idx * w)) & ((WAIT_VEC_MAX'(1) << w) - WAIT_VEC_MAX'(1));
    return sh[WAIT_FIELD_MAX-1:0];
  endfunction

endpackage

// File: rtl/ta_sequencer_space_select.sv
// Priority encoder: lowest set SPACE_SEL bit picks the space and its
// wait-state, burst and cache-inhibit attributes.
module ta_space_select
  import ta_seq_pkg::*;
#(
  parameter int                          N_SPACES    = 4,
  parameter int                          WAIT_W      = 4,
  parameter logic [N_SPACES*WAIT_W-1:0]  WAIT_STATES = 16'h0003,
  parameter logic [N_SPACES-1:0]         BURST_MASK  = 4'b0000,
  parameter logic [N_SPACES-1:0]         CI_MASK     = 4'b0000
) (
  input  logic [N_SPACES-1:0] space_sel,
  output logic                sel_valid,
  output logic [WAIT_W-1:0]   sel_wait,
  output logic                sel_burst,
  output logic                sel_ci
);

  localparam int IDX_W = (N_SPACES > 1) ? $clog2(N_SPACES) : 1;

  logic [IDX_W-1:0] idx;

  always_comb begin
    idx       = '0;
    sel_valid = 1'b0;
    for (int i = N_SPACES - 1; i >= 0; i--) begin
      if (space_sel[i]) begin
        idx       = IDX_W'(i);
        sel_valid = 1'b1;
      end
    end
    sel_wait  = WAIT_W'(wait_field(WAIT_VEC_MAX'(WAIT_STATES), 32'(idx), WAIT_W));
    sel_burst = BURST_MASK[idx];
    sel_ci    = CI_MASK[idx];
  end

endmodule

// File: rtl/ta_sequencer.sv
// MC68040 TA/TBI/TCI generator for N decoded spaces with wait states and
// 4-beat line bursts. Optional bus timeout: define TA_SEQ_TIMEOUT_EN.
module ta_sequencer
  import ta_seq_pkg::*;
#(
  parameter int                          N_SPACES    = 4,
  parameter int                          WAIT_W      = 4,
  parameter logic [N_SPACES*WAIT_W-1:0]  WAIT_STATES = 16'h0003,
  parameter int                          BEAT_WAIT   = 0,
  parameter logic [N_SPACES-1:0]         BURST_MASK  = 4'b0000,
  parameter logic [N_SPACES-1:0]         CI_MASK     = 4'b0000
`ifdef TA_SEQ_TIMEOUT_EN
  , parameter int                        TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                CLK40,
  input  logic                nRESET,
  input  logic                nTS,
  input  logic [1:0]          SIZ,
  input  logic [N_SPACES-1:0] SPACE_SEL,
`ifdef TA_SEQ_TIMEOUT_EN
  input  logic                nTA_IN,
  output logic                nTEA_OUT,
`endif
  output logic                nTA_OUT,
  output logic                nTBI_OUT,
  output logic                nTCI_OUT,
  output logic                BUS_OE,
  output logic                BUSY
);

`ifdef TA_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = (TMO_W > WAIT_W) ? TMO_W : WAIT_W;
`else
  localparam int CNT_W = WAIT_W;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       beats_q, beats_d;
  logic             tbi_q, tbi_d;
  logic             ci_q, ci_d;

  logic              sel_valid;
  logic [WAIT_W-1:0] sel_wait;
  logic              sel_burst;
  logic              sel_ci;

  ta_space_select #(
    .N_SPACES    (N_SPACES),
    .WAIT_W      (WAIT_W),
    .WAIT_STATES (WAIT_STATES),
    .BURST_MASK  (BURST_MASK),
    .CI_MASK     (CI_MASK)
  ) u_sel (
    .space_sel (SPACE_SEL),
    .sel_valid (sel_valid),
    .sel_wait  (sel_wait),
    .sel_burst (sel_burst),
    .sel_ci    (sel_ci)
  );

  // Attributes a new transfer would load if captured this clock.
  logic   siz_line;
  logic   capture;
  state_e load_state;
  logic [2:0] load_beats;

  assign siz_line   = (SIZ == SIZ_LINE);
  assign capture    = !nTS && sel_valid;
  assign load_state = (sel_wait == '0) ? ST_ACK : ST_WAIT;
  assign load_beats = (siz_line && sel_burst) ? 3'(LINE_BEATS) : 3'd1;

`ifdef TA_SEQ_TIMEOUT_EN
  logic sel_multi;
  assign sel_multi = |(SPACE_SEL & (SPACE_SEL - N_SPACES'(1)));
`endif

  always_ff @(posedge CLK40 or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      beats_q <= '0;
      tbi_q   <= 1'b0;
      ci_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      tbi_q   <= tbi_d;
      ci_q    <= ci_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beats_d  = beats_q;
    tbi_d    = tbi_q;
    ci_d     = ci_q;
    nTA_OUT  = 1'b1;
    nTBI_OUT = 1'b1;
    nTCI_OUT = 1'b1;
    BUS_OE   = 1'b0;
    BUSY     = (state_q != ST_IDLE);
`ifdef TA_SEQ_TIMEOUT_EN
    nTEA_OUT = 1'b1;
`endif

    case (state_q)
      ST_IDLE, ST_RECOVER: begin
        BUS_OE  = (state_q == ST_RECOVER);
        state_d = ST_IDLE;
        // RECOVER also accepts a new TS so back-to-back cycles lose no clock.
        if (capture) begin
          state_d = load_state;
          cnt_d   = CNT_W'(sel_wait);
          beats_d = load_beats;
          tbi_d   = siz_line && !sel_burst;
          ci_d    = sel_ci;
`ifdef TA_SEQ_TIMEOUT_EN
          if (sel_multi) state_d = ST_TEA;
        end else if (!nTS) begin
          state_d = ST_TIMEOUT;
          cnt_d   = CNT_W'(TIMEOUT_CYCLES);
`endif
        end
      end

      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) state_d = ST_ACK;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end

      ST_ACK: begin
        nTA_OUT  = 1'b0;
        nTBI_OUT = !tbi_q;
        nTCI_OUT = !ci_q;
        BUS_OE   = 1'b1;
        beats_d  = beats_q - 3'd1;
        if (beats_q > 3'd1) begin
          if (BEAT_WAIT == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_BEAT;
            cnt_d   = CNT_W'(BEAT_WAIT);
          end
        end else begin
          state_d = ST_RECOVER;
        end
      end

      // TA is held driven high between beats rather than released.
      ST_BEAT: begin
        BUS_OE = 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = ST_ACK;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end

`ifdef TA_SEQ_TIMEOUT_EN
      ST_TIMEOUT: begin
        if (!nTA_IN)                 state_d = ST_IDLE;
        else if (cnt_q <= CNT_W'(1)) state_d = ST_TEA;
        else                         cnt_d   = cnt_q - CNT_W'(1);
      end

      ST_TEA: begin
        nTEA_OUT = 1'b0;
        BUS_OE   = 1'b1;
        state_d  = ST_RECOVER;
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ta_sequencer.sv
// Directed bench for ta_sequencer: a default-parameter instance and a
// burst/cache-inhibit instance share the same bus stimulus.
module tb_ta_sequencer;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       nts = 1'b1;
  logic [1:0] siz = 2'b00;
  logic [3:0] sel = 4'b0000;

  logic u0_nta, u0_ntbi, u0_ntci, u0_oe, u0_busy;
  logic u1_nta, u1_ntbi, u1_ntci, u1_oe, u1_busy;
`ifdef TA_SEQ_TIMEOUT_EN
  logic nta_in = 1'b1;
  logic u0_ntea, u1_ntea;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ta_sequencer u0 (
    .CLK40     (clk),
    .nRESET    (nreset),
    .nTS       (nts),
    .SIZ       (siz),
    .SPACE_SEL (sel),
`ifdef TA_SEQ_TIMEOUT_EN
    .nTA_IN    (nta_in),
    .nTEA_OUT  (u0_ntea),
`endif
    .nTA_OUT   (u0_nta),
    .nTBI_OUT  (u0_ntbi),
    .nTCI_OUT  (u0_ntci),
    .BUS_OE    (u0_oe),
    .BUSY      (u0_busy)
  );

  ta_sequencer #(
    .WAIT_STATES (16'h0203),
    .BEAT_WAIT   (1),
    .BURST_MASK  (4'b0010),
    .CI_MASK     (4'b0100)
  ) u1 (
    .CLK40     (clk),
    .nRESET    (nreset),
    .nTS       (nts),
    .SIZ       (siz),
    .SPACE_SEL (sel),
`ifdef TA_SEQ_TIMEOUT_EN
    .nTA_IN    (nta_in),
    .nTEA_OUT  (u1_ntea),
`endif
    .nTA_OUT   (u1_nta),
    .nTBI_OUT  (u1_ntbi),
    .nTCI_OUT  (u1_ntci),
    .BUS_OE    (u1_oe),
    .BUSY      (u1_busy)
  );

  // Observation words {nTA, nTBI, nTCI, BUS_OE, BUSY}.
  logic [4:0] o0, o1;
  assign o0 = {u0_nta, u0_ntbi, u0_ntci, u0_oe, u0_busy};
  assign o1 = {u1_nta, u1_ntbi, u1_ntci, u1_oe, u1_busy};

  localparam logic [4:0] IDLE_W = 5'b11100;
  localparam logic [4:0] WAIT_W = 5'b11101;
  localparam logic [4:0] ACK_W  = 5'b01111;
  localparam logic [4:0] HOLD_W = 5'b11111;

  // Present nTS for one clock; returns #1 after the capture edge (cycle 1).
  task automatic start_cycle(input logic [3:0] s, input logic [1:0] z);
    @(negedge clk);
    nts = 1'b0;
    sel = s;
    siz = z;
    @(posedge clk);
    #1;
    nts = 1'b1;
    sel = 4'b0000;
    siz = 2'b00;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((u0_busy !== 1'b0 || u1_busy !== 1'b0) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 60) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle: busy u0=%b u1=%b, required both 0 within 60 clocks", u0_busy, u1_busy);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (o0 !== IDLE_W) begin
      miscompares++;
      $display("FAIL reset_u0: got %b required %b", o0, IDLE_W);
    end
    vectors++;
    if (o1 !== IDLE_W) begin
      miscompares++;
      $display("FAIL reset_u1: got %b required %b", o1, IDLE_W);
    end
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_wait3();
    logic [4:0] e [6] = '{WAIT_W, WAIT_W, WAIT_W, ACK_W, HOLD_W, IDLE_W};
    wait_idle();
    start_cycle(4'b0001, 2'b00);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      vectors++;
      if (o0 !== e[k]) begin
        miscompares++;
        $display("FAIL single_wait3 cycle %0d: got %b required %b", k + 1, o0, e[k]);
      end
    end
  endtask

  task automatic test_burst();
    logic [4:0] e [9] = '{ACK_W, HOLD_W, ACK_W, HOLD_W, ACK_W, HOLD_W, ACK_W, HOLD_W, IDLE_W};
    wait_idle();
    start_cycle(4'b0010, 2'b11);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      vectors++;
      if (o1 !== e[k]) begin
        miscompares++;
        $display("FAIL burst cycle %0d: got %b required %b", k + 1, o1, e[k]);
      end
    end
  endtask

  task automatic test_line_inhibit();
    logic [4:0] e [5] = '{WAIT_W, WAIT_W, 5'b00011, HOLD_W, IDLE_W};
    wait_idle();
    start_cycle(4'b0100, 2'b11);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      vectors++;
      if (o1 !== e[k]) begin
        miscompares++;
        $display("FAIL line_inhibit cycle %0d: got %b required %b", k + 1, o1, e[k]);
      end
    end
  endtask

  task automatic test_multi_hot();
`ifdef TA_SEQ_TIMEOUT_EN
    logic [4:0] e [3] = '{HOLD_W, HOLD_W, IDLE_W};
`else
    logic [4:0] e [3] = '{ACK_W, HOLD_W, IDLE_W};
`endif
    wait_idle();
    start_cycle(4'b0110, 2'b00);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      vectors++;
      if (o1 !== e[k]) begin
        miscompares++;
        $display("FAIL multi_hot cycle %0d: got %b required %b", k + 1, o1, e[k]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [4:0] e [6] = '{WAIT_W, WAIT_W, WAIT_W, ACK_W, HOLD_W, IDLE_W};
    wait_idle();
    start_cycle(4'b0001, 2'b00);
    @(posedge clk);
    #3;
    nreset = 1'b0;
    #1;
    vectors++;
    if (o0 !== IDLE_W) begin
      miscompares++;
      $display("FAIL reset_mid_wait async: got %b required %b", o0, IDLE_W);
    end
    @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    start_cycle(4'b0001, 2'b00);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      vectors++;
      if (o0 !== e[k]) begin
        miscompares++;
        $display("FAIL reset_mid_wait rerun cycle %0d: got %b required %b", k + 1, o0, e[k]);
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [4:0] e [7] = '{WAIT_W, WAIT_W, WAIT_W, ACK_W, HOLD_W, IDLE_W, IDLE_W};
    wait_idle();
    start_cycle(4'b0001, 2'b00);
    for (int k = 0; k < 7; k++) begin
      if (k == 1) begin
        start_cycle(4'b0001, 2'b00);
      end else if (k > 0) begin
        @(posedge clk);
        #1;
      end
      vectors++;
      if (o0 !== e[k]) begin
        miscompares++;
        $display("FAIL ignore_busy cycle %0d: got %b required %b", k + 1, o0, e[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e [11] = '{WAIT_W, WAIT_W, WAIT_W, ACK_W, HOLD_W,
                           WAIT_W, WAIT_W, WAIT_W, ACK_W, HOLD_W, IDLE_W};
    wait_idle();
    start_cycle(4'b0001, 2'b00);
    for (int k = 0; k < 11; k++) begin
      if (k == 5) begin
        start_cycle(4'b0001, 2'b00);
      end else if (k > 0) begin
        @(posedge clk);
        #1;
      end
      vectors++;
      if (o0 !== e[k]) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: got %b required %b", k + 1, o0, e[k]);
      end
    end
  endtask

  task automatic test_foreign();
`ifdef TA_SEQ_TIMEOUT_EN
    logic [4:0] msk = 5'b11110;
`else
    logic [4:0] msk = 5'b11111;
`endif
    wait_idle();
    start_cycle(4'b0000, 2'b00);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      vectors++;
      if ((o0 & msk) !== (IDLE_W & msk)) begin
        miscompares++;
        $display("FAIL foreign cycle %0d: got %b required %b", k + 1, o0, IDLE_W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_wait3();
    test_burst();
    test_line_inhibit();
    test_multi_hot();
    test_reset_mid_wait();
    test_ignore_busy();
    test_back_to_back();
    test_foreign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ta_sequencer.md
Name: ta_sequencer

Overview:
- Parametrised MC68040 transfer-acknowledge generator for N locally decoded address spaces.
- Successor to the single-space ROM ack delay. Adds per-space wait states, burst (line) transfers of 4 beats, and per-space TBI/TCI policy.
- Sits between the address decoder, which supplies one-hot space selects, and the 68040 bus. Drives nTA, nTBI and nTCI with active-high-then-release tristate control.

Parameters:
- N_SPACES, 4: number of decoded spaces. Index 0 has highest priority.
- WAIT_W, 4: width of one wait-state field.
- WAIT_STATES, 16'h0003: packed N_SPACES*WAIT_W. Field i is the CLK40 wait states before the first TA of space i.
- BEAT_WAIT, 0: wait states between burst beats, 0..(2^WAIT_W)-1.
- BURST_MASK, 4'b0000: bit i=1 means space i may burst. Otherwise TBI is asserted with TA.
- CI_MASK, 4'b0000: bit i=1 means TCI is asserted with every TA of space i.

Ports:
- CLK40  in  1  bus clock; all logic on its rising edge.
- nRESET  in  1  asynchronous active-low reset.
- nTS  in  1  68040 transfer start, low for one clock.
- SIZ  in  2  68040 size; 2'b11 = line transfer.
- SPACE_SEL  in  N_SPACES  one-hot (or multi-hot) decode, valid on the nTS edge.
- nTA_OUT  out  1  transfer acknowledge drive value.
- nTBI_OUT  out  1  burst inhibit drive value.
- nTCI_OUT  out  1  cache inhibit drive value.
- BUS_OE  out  1  high = drive nTA/nTBI/nTCI pads; low = tristate.
- BUSY  out  1  high from the cycle after the TS capture until recovery completes.

Behaviour:
- Clock and reset: reset nRESET, asynchronous, active-low; clock CLK40.
- Reset values:
  - nTA_OUT=1, nTBI_OUT=1, nTCI_OUT=1, BUS_OE=0, BUSY=0.
  - State IDLE, counters 0.
  - Reset asserted mid-cycle returns to these values immediately, without waiting for a clock.
- States: IDLE, WAIT, ACK, BEAT, RECOVER.
- IDLE:
  - Capture happens on a rising edge with nTS=0 and any SPACE_SEL bit set.
  - On capture, latch S = lowest set index, LINE = (SIZ==2'b11) && BURST_MASK[S], BEATS = LINE ? 4 : 1.
  - Load CNT = WAIT_STATES[S].
  - If CNT==0, go to ACK, else WAIT.
  - nTS=0 with SPACE_SEL==0 is ignored (a foreign responder owns the cycle).
- WAIT: decrement CNT each clock; when CNT reaches 1, go to ACK.
- Timing: nTA_OUT low is first visible in the clock after the capture edge plus WAIT_STATES[S] clocks.
- ACK (one clock per beat):
  - nTA_OUT=0 and BUS_OE=1.
  - nTBI_OUT = 0 if !BURST_MASK[S] and SIZ was line; otherwise 1. TBI is asserted only on the single beat of an inhibited line.
  - nTCI_OUT = !CI_MASK[S].
  - After this beat, decrement the beat count.
  - If beats remain: go to BEAT with CNT=BEAT_WAIT, or directly to another ACK if BEAT_WAIT==0.
  - If no beats remain, go to RECOVER.
- BEAT: nTA_OUT=1 with BUS_OE=1 (held high, not released); count BEAT_WAIT down, then return to ACK.
- RECOVER:
  - One clock with all three outputs =1 and BUS_OE=1, so the next cycle cannot terminate early.
  - Then go to IDLE, BUS_OE=0, BUSY=0.
- Back-to-back: nTS asserted in the RECOVER clock is captured. The next ack then begins with no idle gap beyond its own wait states.
- nTS in WAIT, ACK or BEAT is ignored; the 68040 does not pipeline.
- Multi-hot SPACE_SEL resolves to the lowest index. No error is flagged unless the optional feature is enabled.
- Worst-case line length is 1 + wait + 4 + 3*BEAT_WAIT + 1 clocks.

Optional Feature:
- Macro TA_SEQ_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYCLES (default 1024) and output nTEA_OUT (reset 1), driven under BUS_OE.
  - An nTS with SPACE_SEL==0 starts a timeout counter.
  - If no external TA is seen by TIMEOUT_CYCLES clocks, the block drives nTEA_OUT=0 for one clock, then one RECOVER clock with nTEA_OUT=1, then releases.
  - This requires an extra input nTA_IN (the pad value). A low nTA_IN aborts the count with no TEA.
  - Multi-hot SPACE_SEL also drives nTEA_OUT instead of nTA_OUT.
- When undefined: no timeout logic, no nTEA_OUT or nTA_IN ports, and foreign cycles are ignored entirely.

Decomposition:
- Package ta_seq_pkg: state encoding (IDLE, WAIT, ACK, BEAT, RECOVER), SIZ_LINE=2'b11, LINE_BEATS=4, and a function to extract wait field i from the packed vector.
- One sub-module, ta_space_select: combinational priority encoder from SPACE_SEL to index S, valid flag, WAIT_STATES field, and BURST/CI bits.

Test Plan:
- Default parameters, nTS with SPACE_SEL=4'b0001, SIZ=2'b00 -> nTA_OUT low exactly 4 clocks after the capture edge, for 1 clock. Then 1 high clock with BUS_OE=1. BUS_OE=0 on the next clock.
- BURST_MASK=4'b0010, WAIT_STATES field1=0, BEAT_WAIT=1, SIZ=2'b11, SPACE_SEL=4'b0010 -> TA pattern 0,1,0,1,0,1,0 starting 1 clock after capture, nTBI_OUT=1 throughout, then recovery.
- Same line transfer on space 2 (not burst-capable), CI_MASK=4'b0100 -> single TA with nTBI_OUT=0 and nTCI_OUT=0 in the same clock.
- SPACE_SEL=4'b0110 -> space 1 parameters used. SPACE_SEL=0 -> BUS_OE stays 0 and BUSY stays 0.
- nRESET pulled low during WAIT (space 0, 2nd wait clock) -> outputs return to reset values immediately. A fresh nTS after release gives a normal 3-wait ack.
- With TA_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, a foreign nTS with no nTA_IN -> nTEA_OUT low on the 17th clock for 1 clock. With nTA_IN pulsed low at clock 5 -> no TEA.
